// File: rtl/operand_request_channel.sv
// rtl/operand_request_channel.sv - per-queue VRF read sequencer with credit-based flow control
//
// Purpose:
//   Sits directly upstream of one operand queue. Accepts an operand request
//   (first VRF word address, word count, queue command), forwards the command
//   to the queue once, then issues one VRF read per granted cycle. A credit
//   counter initialised to the queue depth guarantees that reads in flight
//   plus words already buffered never exceed the queue capacity.
//
// Ports:
//   clk_i                      in   clock
//   rst_i                      in   asynchronous active-high reset
//   req_valid_i / req_ready_o  in/out  request handshake (accepted only in IDLE)
//   req_addr_i                 in   first VRF word address
//   req_len_i                  in   words to read, 0 = no-op
//   req_cmd_i                  in   opaque command for the operand queue
//   vrf_req_o                  out  VRF read request to the bank arbiter
//   vrf_addr_o                 out  VRF read address (held while not granted)
//   vrf_gnt_i                  in   arbiter grant, only meaningful with vrf_req_o
//   operand_issued_o           out  a read fired this cycle
//   operand_queue_cmd_o        out  command to the operand queue
//   operand_queue_cmd_valid_o  out  one-cycle command strobe per non-empty request
//   credit_return_i            in   queue handed one word to its VFU
//   busy_o                     out  request in progress

module operand_request_channel #(
  parameter int unsigned BufferDepth = 5,
  parameter int unsigned AddrWidth   = 16,
  parameter int unsigned LenWidth    = 16,
  parameter int unsigned CmdWidth    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [LenWidth-1:0]  req_len_i,
  input  logic [CmdWidth-1:0]  req_cmd_i,
  output logic                 vrf_req_o,
  output logic [AddrWidth-1:0] vrf_addr_o,
  input  logic                 vrf_gnt_i,
  output logic                 operand_issued_o,
  output logic [CmdWidth-1:0]  operand_queue_cmd_o,
  output logic                 operand_queue_cmd_valid_o,
  input  logic                 credit_return_i,
  output logic                 busy_o
);

  localparam int unsigned CreditWidth = $clog2(BufferDepth + 1);
  localparam logic [CreditWidth-1:0] CreditMax = CreditWidth'(BufferDepth);

  typedef enum logic {
    StIdle  = 1'b0,
    StIssue = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [LenWidth-1:0]    remaining_q, remaining_d;
  logic [CmdWidth-1:0]    cmd_q, cmd_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [CreditWidth-1:0] credits_q, credits_d;

  logic accept;
  logic fire;
  logic last_fire;
  logic has_credit;
  logic non_empty_req;

  assign has_credit    = (credits_q != '0);
  assign non_empty_req = (req_len_i != '0);
  assign accept        = req_valid_i & req_ready_o;
  // A grant only counts when we are actually requesting.
  assign fire          = vrf_req_o & vrf_gnt_i;
  assign last_fire     = fire & (remaining_q == LenWidth'(1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        // Zero-length requests are consumed without leaving IDLE.
        if (accept && non_empty_req) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (last_fire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready_o = 1'b0;
    busy_o      = 1'b0;
    vrf_req_o   = 1'b0;
    case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
      end
      StIssue: begin
        busy_o    = 1'b1;
        // Without a free queue slot the read must not even be requested.
        vrf_req_o = has_credit;
      end
      default: begin
        req_ready_o = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request datapath: address, remaining count, command and command strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    if (accept) begin
      addr_d      = req_addr_i;
      remaining_d = req_len_i;
      cmd_d       = req_cmd_i;
      cmd_valid_d = non_empty_req;
    end else if (fire) begin
      // Address wraps silently at the top of the VRF word space.
      addr_d      = addr_q + AddrWidth'(1);
      remaining_d = remaining_q - LenWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      remaining_q <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Credit counter: one slot consumed per fired read, one freed per return.
  // Returns keep arriving in IDLE because buffered words drain after the
  // request has finished issuing.
  // ---------------------------------------------------------------------------
  always_comb begin
    credits_d = credits_q;
    case ({fire, credit_return_i})
      2'b10: credits_d = credits_q - CreditWidth'(1);
      2'b01: begin
        // A return with every slot already free is a protocol error upstream;
        // saturate rather than wrap.
        if (credits_q != CreditMax) begin
          credits_d = credits_q + CreditWidth'(1);
        end
      end
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credits_q <= CreditMax;
    end else begin
      credits_q <= credits_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign vrf_addr_o                = addr_q;
  assign operand_issued_o          = fire;
  assign operand_queue_cmd_o       = cmd_q;
  assign operand_queue_cmd_valid_o = cmd_valid_q;

  credit_overflow_a : assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(credit_return_i && !fire && (credits_q == CreditMax))
  ) else $error("credit return received while credit counter is full");

endmodule

// File: tb/tb_operand_request_channel.sv
// tb/tb_operand_request_channel.sv - self-checking bench for operand_request_channel
module tb_operand_request_channel;

  localparam int D  = 5;
  localparam int AW = 16;
  localparam int LW = 16;
  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic [LW-1:0] req_len_i = '0;
  logic [CW-1:0] req_cmd_i = '0;
  logic          vrf_req_o;
  logic [AW-1:0] vrf_addr_o;
  logic          vrf_gnt_i = 1'b0;
  logic          operand_issued_o;
  logic [CW-1:0] operand_queue_cmd_o;
  logic          operand_queue_cmd_valid_o;
  logic          credit_return_i = 1'b0;
  logic          busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  operand_request_channel #(
    .BufferDepth(D), .AddrWidth(AW), .LenWidth(LW), .CmdWidth(CW)
  ) dut (
    .clk_i                     (clk_i),
    .rst_i                     (rst_i),
    .req_valid_i               (req_valid_i),
    .req_ready_o               (req_ready_o),
    .req_addr_i                (req_addr_i),
    .req_len_i                 (req_len_i),
    .req_cmd_i                 (req_cmd_i),
    .vrf_req_o                 (vrf_req_o),
    .vrf_addr_o                (vrf_addr_o),
    .vrf_gnt_i                 (vrf_gnt_i),
    .operand_issued_o          (operand_issued_o),
    .operand_queue_cmd_o       (operand_queue_cmd_o),
    .operand_queue_cmd_valid_o (operand_queue_cmd_valid_o),
    .credit_return_i           (credit_return_i),
    .busy_o                    (busy_o)
  );

  // Reference model: list of word addresses still to be read, free queue slots,
  // and the command strobe expected this cycle.
  logic [AW-1:0] exp_q[$];
  int            m_credits;
  logic [CW-1:0] m_cmd;
  bit            m_cmd_pulse;

  function automatic bit m_req();
    return (exp_q.size() != 0) && (m_credits > 0);
  endfunction

  function automatic bit m_fire();
    return m_req() && (vrf_gnt_i === 1'b1);
  endfunction

  // A return is only legal if it does not push free slots past the depth.
  function automatic bit ret_ok();
    return (m_credits < D) || m_fire();
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_credits   = D;
    m_cmd       = '0;
    m_cmd_pulse = 0;
  endtask

  // Folds the current cycle's inputs into the model, then moves past the edge.
  task automatic advance();
    bit fire;
    bit accept;
    fire   = m_fire();
    accept = (req_valid_i === 1'b1) && (exp_q.size() == 0);
    m_cmd_pulse = 0;
    if (fire) void'(exp_q.pop_front());
    m_credits = m_credits - int'(fire) + int'(credit_return_i);
    if (m_credits > D) m_credits = D;
    if (accept) begin
      m_cmd = req_cmd_i;
      for (int i = 0; i < int'(req_len_i); i++) exp_q.push_back(req_addr_i + AW'(i));
      m_cmd_pulse = (req_len_i != '0);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    req_valid_i = 1'b0;
    vrf_gnt_i   = 1'b1;
    for (int i = 0; i < 60 && !(exp_q.size() == 0 && m_credits == D); i++) begin
      credit_return_i = ret_ok();
      advance();
    end
    credit_return_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_idle: ready=%b busy=%b pending=%0d, required ready=1 busy=0 pending=0",
               req_ready_o, busy_o, exp_q.size());
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++;
    if ({req_ready_o, vrf_req_o, busy_o, operand_issued_o, operand_queue_cmd_valid_o} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 10000", {req_ready_o, vrf_req_o, busy_o,
               operand_issued_o, operand_queue_cmd_valid_o});
    end
    n_cmp++;
    if (vrf_addr_o !== '0 || operand_queue_cmd_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h cmd=%h required 0", vrf_addr_o, operand_queue_cmd_o);
    end
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic [CW-1:0] cmd;
    cmd = CW'($urandom);
    vrf_gnt_i = 1'b1; req_addr_i = 16'h0010; req_len_i = 3; req_cmd_i = cmd; req_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      credit_return_i = ret_ok();
      @(negedge clk_i);
      n_cmp++;
      if (operand_queue_cmd_valid_o !== (c == 1)) begin
        n_fail++;
        $display("FAIL basic_cmd_valid c%0d: got %b required %b", c, operand_queue_cmd_valid_o, (c == 1));
      end
      if (c == 1) begin
        n_cmp++;
        if (operand_queue_cmd_o !== cmd) begin
          n_fail++;
          $display("FAIL basic_cmd: got %h required %h", operand_queue_cmd_o, cmd);
        end
      end
      n_cmp++;
      if (operand_issued_o !== (c >= 1 && c <= 3)) begin
        n_fail++;
        $display("FAIL basic_issued c%0d: got %b required %b", c, operand_issued_o, (c >= 1 && c <= 3));
      end
      if (c >= 1 && c <= 3) begin
        n_cmp++;
        if (vrf_addr_o !== 16'h0010 + AW'(c - 1)) begin
          n_fail++;
          $display("FAIL basic_addr c%0d: got %h required %h", c, vrf_addr_o, 16'h0010 + AW'(c - 1));
        end
      end
      n_cmp++;
      if (req_ready_o !== (c == 0 || c == 4)) begin
        n_fail++;
        $display("FAIL basic_ready c%0d: got %b required %b", c, req_ready_o, (c == 0 || c == 4));
      end
      advance();
      req_valid_i = 1'b0;
    end
    credit_return_i = 1'b0;
  endtask

  task automatic test_credit_stall();
    int issued;
    issued = 0;
    vrf_gnt_i = 1'b1; credit_return_i = 1'b0;
    req_addr_i = 16'h0100; req_len_i = 8; req_cmd_i = CW'($urandom); req_valid_i = 1'b1;
    @(negedge clk_i);
    advance();
    req_valid_i = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      if (operand_issued_o === 1'b1) begin
        n_cmp++;
        if (vrf_addr_o !== 16'h0100 + AW'(issued)) begin
          n_fail++;
          $display("FAIL stall_addr: got %h required %h", vrf_addr_o, 16'h0100 + AW'(issued));
        end
        issued++;
      end
      advance();
    end
    n_cmp++;
    if (issued != D) begin
      n_fail++;
      $display("FAIL stall_count: got %0d reads required %0d", issued, D);
    end
    @(negedge clk_i);
    n_cmp++;
    if (vrf_req_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold: vrf_req=%b busy=%b required 0 1", vrf_req_o, busy_o);
    end
    advance();
    for (int k = 0; k < 2; k++) begin
      credit_return_i = 1'b1;
      @(negedge clk_i);
      advance();
      credit_return_i = 1'b0;
      @(negedge clk_i);
      n_cmp++;
      if (operand_issued_o !== 1'b1 || vrf_addr_o !== 16'h0105 + AW'(k)) begin
        n_fail++;
        $display("FAIL stall_resume k%0d: issued=%b addr=%h required 1 %h", k, operand_issued_o,
                 vrf_addr_o, 16'h0105 + AW'(k));
      end
      advance();
    end
    drain();
  endtask

  task automatic test_zero_len();
    vrf_gnt_i = 1'b1; credit_return_i = 1'b0;
    req_addr_i = AW'($urandom); req_len_i = 0; req_cmd_i = CW'($urandom); req_valid_i = 1'b1;
    @(negedge clk_i);
    advance();
    req_valid_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      n_cmp++;
      if ({req_ready_o, busy_o, vrf_req_o, operand_issued_o, operand_queue_cmd_valid_o} !== 5'b10000) begin
        n_fail++;
        $display("FAIL zero_len: ready/busy/req/issued/cmd_valid=%b required 10000",
                 {req_ready_o, busy_o, vrf_req_o, operand_issued_o, operand_queue_cmd_valid_o});
      end
      advance();
    end
  endtask

  task automatic test_gnt_withheld();
    vrf_gnt_i = 1'b0; credit_return_i = 1'b0;
    req_addr_i = 16'h0020; req_len_i = 1; req_cmd_i = CW'($urandom); req_valid_i = 1'b1;
    @(negedge clk_i);
    advance();
    req_valid_i = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      n_cmp++;
      if (vrf_req_o !== 1'b1 || vrf_addr_o !== 16'h0020 || operand_issued_o !== 1'b0) begin
        n_fail++;
        $display("FAIL gnt_wait: req=%b addr=%h issued=%b required 1 0020 0", vrf_req_o, vrf_addr_o,
                 operand_issued_o);
      end
      advance();
    end
    vrf_gnt_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if (operand_issued_o !== 1'b1) begin
      n_fail++;
      $display("FAIL gnt_fire: issued=%b required 1", operand_issued_o);
    end
    credit_return_i = 1'b1;
    advance();
    credit_return_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (vrf_addr_o !== 16'h0021 || operand_issued_o !== 1'b0 || req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL gnt_after: addr=%h issued=%b ready=%b required 0021 0 1", vrf_addr_o,
               operand_issued_o, req_ready_o);
    end
    advance();
  endtask

  task automatic test_wrap_credit();
    // Consume D-1 slots with no returns so exactly one credit remains.
    vrf_gnt_i = 1'b1; credit_return_i = 1'b0;
    req_addr_i = 16'h0300; req_len_i = LW'(D - 1); req_valid_i = 1'b1;
    @(negedge clk_i);
    advance();
    req_valid_i = 1'b0;
    repeat (D) begin
      @(negedge clk_i);
      advance();
    end
    req_addr_i = 16'hFFFF; req_len_i = 2; req_valid_i = 1'b1;
    @(negedge clk_i);
    advance();
    req_valid_i = 1'b0;
    credit_return_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      n_cmp++;
      if (operand_issued_o !== 1'b1 || vrf_addr_o !== (k == 0 ? 16'hFFFF : 16'h0000)) begin
        n_fail++;
        $display("FAIL wrap_credit k%0d: issued=%b addr=%h required 1 %h", k, operand_issued_o,
                 vrf_addr_o, (k == 0 ? 16'hFFFF : 16'h0000));
      end
      advance();
    end
    drain();
  endtask

  task automatic test_mid_reset();
    int issued;
    vrf_gnt_i = 1'b1; credit_return_i = 1'b0;
    req_addr_i = 16'h0400; req_len_i = 6; req_valid_i = 1'b1;
    @(negedge clk_i);
    advance();
    req_valid_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      advance();
    end
    n_cmp++;
    if (vrf_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: vrf_req=%b required 1", vrf_req_o);
    end
    #1 rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready_o, vrf_req_o, busy_o, operand_issued_o, operand_queue_cmd_valid_o} !== 5'b10000
        || vrf_addr_o !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: ctrl=%b addr=%h required 10000 0000", {req_ready_o, vrf_req_o,
               busy_o, operand_issued_o, operand_queue_cmd_valid_o}, vrf_addr_o);
    end
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    model_reset();
    // Full credit pool after reset: a long request with no returns gets exactly D reads.
    issued = 0;
    req_addr_i = 16'h0500; req_len_i = 8; req_valid_i = 1'b1;
    @(negedge clk_i);
    advance();
    req_valid_i = 1'b0;
    repeat (9) begin
      @(negedge clk_i);
      if (operand_issued_o === 1'b1) issued++;
      advance();
    end
    n_cmp++;
    if (issued != D) begin
      n_fail++;
      $display("FAIL midrst_credits: got %0d reads required %0d", issued, D);
    end
    drain();
  endtask

  task automatic test_random();
    bit exp_fire;
    for (int cyc = 0; cyc < 500; cyc++) begin
      vrf_gnt_i   = ($urandom_range(0, 99) < 70);
      req_valid_i = ($urandom_range(0, 3) == 0);
      req_len_i   = LW'($urandom_range(0, 9));
      req_addr_i  = ($urandom_range(0, 3) == 0) ? AW'(32'hFFFF - $urandom_range(0, 4)) : AW'($urandom);
      req_cmd_i   = CW'($urandom);
      credit_return_i = ($urandom_range(0, 1) == 1) && ret_ok();
      @(negedge clk_i);
      exp_fire = m_fire();
      n_cmp++;
      if (req_ready_o !== (exp_q.size() == 0) || busy_o !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL rand_state cyc%0d: ready=%b busy=%b required pending=%0d", cyc, req_ready_o,
                 busy_o, exp_q.size());
      end
      n_cmp++;
      if (vrf_req_o !== m_req() || operand_issued_o !== exp_fire) begin
        n_fail++;
        $display("FAIL rand_req cyc%0d: req=%b issued=%b required %b %b", cyc, vrf_req_o,
                 operand_issued_o, m_req(), exp_fire);
      end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if (vrf_addr_o !== exp_q[0]) begin
          n_fail++;
          $display("FAIL rand_addr cyc%0d: got %h required %h", cyc, vrf_addr_o, exp_q[0]);
        end
      end
      n_cmp++;
      if (operand_queue_cmd_valid_o !== m_cmd_pulse || (m_cmd_pulse && operand_queue_cmd_o !== m_cmd)) begin
        n_fail++;
        $display("FAIL rand_cmd cyc%0d: valid=%b cmd=%h required %b %h", cyc,
                 operand_queue_cmd_valid_o, operand_queue_cmd_o, m_cmd_pulse, m_cmd);
      end
      advance();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit_stall();
    test_zero_len();
    test_gnt_withheld();
    test_wrap_credit();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
